// File: rtl/advtim_seq_ctrl.sv
// Profile sequencer for the advanced-timer PWM generator: steps ARR/CC1 profiles with repeat counts.
// Optional watchdog on generator reloads is enabled by defining ADVTIM_SEQ_WDOG_EN.
module advtim_seq_ctrl #(
    parameter int NPROF = 4,
    parameter int REPW  = 8
) (
    input  logic            pe_gen_clk,
    input  logic            pe_gen_rst,
    input  logic            seq_start,
    input  logic            seq_stop,
    input  logic            seq_fault_clr,
    input  logic            seq_loop,
    input  logic [1:0]      seq_last,
    input  logic            prof_wr_en,
    input  logic [1:0]      prof_wr_idx,
    input  logic [15:0]     prof_wr_arr,
    input  logic [15:0]     prof_wr_cc1,
    input  logic [REPW-1:0] prof_wr_rep,
    input  logic            gen_hw_update,
    input  logic            gen_reloaded,
    input  logic            fault_detected,
`ifdef ADVTIM_SEQ_WDOG_EN
    input  logic [23:0]     seq_wdog_lim,
    output logic            seq_wdog_to,
`endif
    output logic            seq_tim_enable,
    output logic            seq_logic_clr,
    output logic [15:0]     seq_arr,
    output logic [15:0]     seq_cc1,
    output logic [1:0]      seq_prof_idx,
    output logic            seq_busy,
    output logic            seq_done,
    output logic            seq_fault
);
    // state  | meaning
    // IDLE   | generator off, outputs mirror slot 0
    // LAUNCH | one-cycle setup before enabling the generator
    // RUN    | generator enabled, stepping through profiles
    // STOP   | generator off, one-cycle logic clear
    // FAULT  | latched fault, waits for clear with fault gone
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, STOP, FAULT} state_t;

    state_t          state, state_nxt;
    logic [15:0]     arr_tab [NPROF];
    logic [15:0]     cc1_tab [NPROF];
    logic [REPW-1:0] rep_tab [NPROF];
    logic [REPW-1:0] rep_cnt, rep_cnt_nxt, rep_eff;
    logic [1:0]      idx_nxt, idx_adv;
    logic [15:0]     arr_nxt, cc1_nxt;
    logic            tim_en_nxt, logic_clr_nxt, busy_nxt, done_nxt, fault_nxt;
    logic            last_rep, at_end, wdog_hit;

    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            for (int i = 0; i < NPROF; i++) begin
                arr_tab[i] <= 16'h0032;
                cc1_tab[i] <= 16'h0000;
                rep_tab[i] <= REPW'(1);
            end
        end else if (prof_wr_en) begin
            arr_tab[prof_wr_idx] <= prof_wr_arr;
            cc1_tab[prof_wr_idx] <= prof_wr_cc1;
            rep_tab[prof_wr_idx] <= prof_wr_rep;
        end
    end

`ifdef ADVTIM_SEQ_WDOG_EN
    logic [23:0] wdog_cnt;

    assign wdog_hit = (state == RUN) && (seq_wdog_lim != 24'd0) && (wdog_cnt + 24'd1 == seq_wdog_lim);

    // Counts RUN cycles since entry or the last reload.
    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            wdog_cnt    <= 24'd0;
            seq_wdog_to <= 1'b0;
        end else begin
            wdog_cnt    <= (state != RUN || gen_reloaded) ? 24'd0 : wdog_cnt + 24'd1;
            seq_wdog_to <= wdog_hit;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    assign rep_eff  = (rep_tab[seq_prof_idx] == '0) ? REPW'(1) : rep_tab[seq_prof_idx];
    assign last_rep = (rep_cnt == rep_eff - REPW'(1));
    assign at_end   = (seq_prof_idx == seq_last) && !seq_loop;
    assign idx_adv  = (seq_prof_idx == seq_last) ? 2'd0 : seq_prof_idx + 2'd1;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = seq_prof_idx;
        rep_cnt_nxt   = rep_cnt;
        arr_nxt       = seq_arr;
        cc1_nxt       = seq_cc1;
        tim_en_nxt    = seq_tim_enable;
        logic_clr_nxt = 1'b0;
        busy_nxt      = seq_busy;
        done_nxt      = 1'b0;
        fault_nxt     = seq_fault;
        if ((fault_detected || wdog_hit) && state != FAULT) begin
            state_nxt     = FAULT;
            tim_en_nxt    = 1'b0;
            logic_clr_nxt = 1'b1;
            busy_nxt      = 1'b0;
            fault_nxt     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    arr_nxt    = arr_tab[0];
                    cc1_nxt    = cc1_tab[0];
                    tim_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    if (seq_start) begin
                        state_nxt   = LAUNCH;
                        idx_nxt     = 2'd0;
                        rep_cnt_nxt = '0;
                        busy_nxt    = 1'b1;
                    end
                end
                LAUNCH: begin
                    if (seq_stop) begin
                        state_nxt     = STOP;
                        logic_clr_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                    end else begin
                        state_nxt  = RUN;
                        tim_en_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (seq_stop) begin
                        state_nxt     = STOP;
                        tim_en_nxt    = 1'b0;
                        logic_clr_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                    end else if (gen_reloaded) begin
                        if (!last_rep) begin
                            rep_cnt_nxt = rep_cnt + REPW'(1);
                        end else begin
                            rep_cnt_nxt = '0;
                            if (at_end) begin
                                state_nxt     = STOP;
                                tim_en_nxt    = 1'b0;
                                logic_clr_nxt = 1'b1;
                                busy_nxt      = 1'b0;
                                done_nxt      = 1'b1;
                            end else begin
                                idx_nxt = idx_adv;
                            end
                        end
                    end else if (gen_hw_update && last_rep && !at_end) begin
                        // Table read here sees the value before any same-cycle write.
                        arr_nxt = arr_tab[idx_adv];
                        cc1_nxt = cc1_tab[idx_adv];
                    end
                end
                STOP: begin
                    state_nxt  = IDLE;
                    tim_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
                FAULT: begin
                    if (seq_fault_clr && !fault_detected) begin
                        state_nxt = IDLE;
                        fault_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            state          <= IDLE;
            seq_prof_idx   <= 2'd0;
            rep_cnt        <= '0;
            seq_arr        <= 16'h0032;
            seq_cc1        <= 16'h0000;
            seq_tim_enable <= 1'b0;
            seq_logic_clr  <= 1'b0;
            seq_busy       <= 1'b0;
            seq_done       <= 1'b0;
            seq_fault      <= 1'b0;
        end else begin
            state          <= state_nxt;
            seq_prof_idx   <= idx_nxt;
            rep_cnt        <= rep_cnt_nxt;
            seq_arr        <= arr_nxt;
            seq_cc1        <= cc1_nxt;
            seq_tim_enable <= tim_en_nxt;
            seq_logic_clr  <= logic_clr_nxt;
            seq_busy       <= busy_nxt;
            seq_done       <= done_nxt;
            seq_fault      <= fault_nxt;
        end
    end
endmodule

// File: tb/tb_advtim_seq_ctrl.sv
// Self-checking bench for advtim_seq_ctrl: directed scenarios plus randomized profile tables
// checked against a period-by-period expected profile list.
module tb_advtim_seq_ctrl;
    localparam int REPW = 8;

    logic            pe_gen_clk = 1'b0;
    logic            pe_gen_rst = 1'b1;
    logic            seq_start = 0, seq_stop = 0, seq_fault_clr = 0, seq_loop = 0;
    logic [1:0]      seq_last = 2'd0;
    logic            prof_wr_en = 0;
    logic [1:0]      prof_wr_idx = 2'd0;
    logic [15:0]     prof_wr_arr = 16'd0, prof_wr_cc1 = 16'd0;
    logic [REPW-1:0] prof_wr_rep = '0;
    logic            gen_hw_update = 0, gen_reloaded = 0, fault_detected = 0;
    logic            seq_tim_enable, seq_logic_clr, seq_busy, seq_done, seq_fault;
    logic [15:0]     seq_arr, seq_cc1;
    logic [1:0]      seq_prof_idx;
`ifdef ADVTIM_SEQ_WDOG_EN
    logic [23:0]     seq_wdog_lim = 24'd0;
    logic            seq_wdog_to;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] m_arr [4];
    logic [15:0] m_cc1 [4];
    int          m_rep [4];

    advtim_seq_ctrl #(.NPROF(4), .REPW(REPW)) dut (
        .pe_gen_clk(pe_gen_clk), .pe_gen_rst(pe_gen_rst),
        .seq_start(seq_start), .seq_stop(seq_stop), .seq_fault_clr(seq_fault_clr),
        .seq_loop(seq_loop), .seq_last(seq_last),
        .prof_wr_en(prof_wr_en), .prof_wr_idx(prof_wr_idx), .prof_wr_arr(prof_wr_arr),
        .prof_wr_cc1(prof_wr_cc1), .prof_wr_rep(prof_wr_rep),
        .gen_hw_update(gen_hw_update), .gen_reloaded(gen_reloaded), .fault_detected(fault_detected),
`ifdef ADVTIM_SEQ_WDOG_EN
        .seq_wdog_lim(seq_wdog_lim), .seq_wdog_to(seq_wdog_to),
`endif
        .seq_tim_enable(seq_tim_enable), .seq_logic_clr(seq_logic_clr),
        .seq_arr(seq_arr), .seq_cc1(seq_cc1), .seq_prof_idx(seq_prof_idx),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_fault(seq_fault)
    );

    always #5 pe_gen_clk = ~pe_gen_clk;

    task automatic tick();
        @(posedge pe_gen_clk);
        #1;
    endtask

    task automatic model_reset_table();
        for (int i = 0; i < 4; i++) begin
            m_arr[i] = 16'h0032;
            m_cc1[i] = 16'h0000;
            m_rep[i] = 1;
        end
    endtask

    task automatic write_prof(input int idx, input logic [15:0] a, input logic [15:0] c, input int r);
        prof_wr_en  = 1'b1;
        prof_wr_idx = 2'(idx);
        prof_wr_arr = a;
        prof_wr_cc1 = c;
        prof_wr_rep = REPW'(r);
        tick();
        prof_wr_en = 1'b0;
        m_arr[idx] = a;
        m_cc1[idx] = c;
        m_rep[idx] = r;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: gen_hw_update = 1'b1;
            1: gen_reloaded  = 1'b1;
            2: seq_stop      = 1'b1;
            default: seq_fault_clr = 1'b1;
        endcase
        tick();
        gen_hw_update = 1'b0;
        gen_reloaded  = 1'b0;
        seq_stop      = 1'b0;
        seq_fault_clr = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) tick();
    endtask

    task automatic launch(input logic [15:0] exp_arr);
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL launch_busy got %0b want 1", seq_busy); end
        checks++; if (seq_tim_enable !== 1'b0) begin errors++; $display("FAIL launch_tim_en got %0b want 0", seq_tim_enable); end
        checks++; if (seq_arr !== exp_arr) begin errors++; $display("FAIL launch_arr got %0d want %0d", seq_arr, exp_arr); end
        tick();
        checks++; if (seq_tim_enable !== 1'b1) begin errors++; $display("FAIL run_tim_en got %0b want 1", seq_tim_enable); end
    endtask

    task automatic test_reset();
        pe_gen_rst = 1'b1;
        idle_gap(2);
        pe_gen_rst = 1'b0;
        model_reset_table();
        checks++; if (seq_arr !== 16'h0032) begin errors++; $display("FAIL rst_arr got %h want 0032", seq_arr); end
        checks++; if (seq_cc1 !== 16'h0000) begin errors++; $display("FAIL rst_cc1 got %h want 0000", seq_cc1); end
        checks++; if ({seq_tim_enable, seq_logic_clr, seq_busy, seq_done, seq_fault} !== 5'b0)
            begin errors++; $display("FAIL rst_flags got %b want 00000", {seq_tim_enable, seq_logic_clr, seq_busy, seq_done, seq_fault}); end
        checks++; if (seq_prof_idx !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", seq_prof_idx); end
        write_prof(0, 16'd777, 16'd7, 1);
        tick();
        checks++; if (seq_arr !== 16'd777) begin errors++; $display("FAIL idle_track_arr got %0d want 777", seq_arr); end
    endtask

    task automatic test_single_pass();
        write_prof(0, 16'd100, 16'd10, 2);
        write_prof(1, 16'd200, 16'd20, 1);
        seq_last = 2'd1; seq_loop = 1'b0;
        tick();
        launch(16'd100);
        pulse(0); pulse(1);
        checks++; if (seq_arr !== 16'd100) begin errors++; $display("FAIL sp_arr_hold got %0d want 100", seq_arr); end
        pulse(0);
        checks++; if (seq_arr !== 16'd200 || seq_cc1 !== 16'd20) begin errors++; $display("FAIL sp_arr_load got %0d/%0d want 200/20", seq_arr, seq_cc1); end
        pulse(1);
        checks++; if (seq_prof_idx !== 2'd1 || seq_done !== 1'b0) begin errors++; $display("FAIL sp_idx got %0d done %0b want 1 done 0", seq_prof_idx, seq_done); end
        pulse(0); pulse(1);
        checks++; if (seq_done !== 1'b1 || seq_logic_clr !== 1'b1 || seq_tim_enable !== 1'b0)
            begin errors++; $display("FAIL sp_done got done %0b clr %0b en %0b want 1 1 0", seq_done, seq_logic_clr, seq_tim_enable); end
        tick();
        checks++; if (seq_done !== 1'b0 || seq_logic_clr !== 1'b0 || seq_busy !== 1'b0)
            begin errors++; $display("FAIL sp_after got done %0b clr %0b busy %0b want 0 0 0", seq_done, seq_logic_clr, seq_busy); end
        tick();
    endtask

    // Expected behaviour: period k runs profile q[k]; q lists each used slot max(rep,1) times in order.
    task automatic test_random_profiles();
        for (int it = 0; it < 8; it++) begin
            int last, loop_en, nper, g;
            int q[$];
            int base[$];
            logic [15:0] exp_arr, exp_cc1;
            for (int p = 0; p < 4; p++)
                write_prof(p, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
            last = int'($urandom_range(0, 3));
            loop_en = int'($urandom_range(0, 1));
            seq_last = 2'(last);
            seq_loop = loop_en[0];
            for (int p = 0; p <= last; p++)
                for (int r = 0; r < ((m_rep[p] == 0) ? 1 : m_rep[p]); r++) base.push_back(p);
            nper = loop_en != 0 ? int'($urandom_range(3, 10)) : base.size();
            q = base;
            while (loop_en != 0 && q.size() < nper + 1) q = {q, base};
            tick();
            launch(m_arr[0]);
            for (int k = 0; k < nper; k++) begin
                g = int'($urandom_range(0, 2)); idle_gap(g);
                pulse(0);
                exp_arr = (k + 1 < q.size()) ? m_arr[q[k+1]] : m_arr[q[k]];
                exp_cc1 = (k + 1 < q.size()) ? m_cc1[q[k+1]] : m_cc1[q[k]];
                checks++; if (seq_arr !== exp_arr || seq_cc1 !== exp_cc1)
                    begin errors++; $display("FAIL rnd_hw it%0d k%0d got %h/%h want %h/%h", it, k, seq_arr, seq_cc1, exp_arr, exp_cc1); end
                g = int'($urandom_range(0, 2)); idle_gap(g);
                pulse(1);
                if (loop_en == 0 && k == nper - 1) begin
                    checks++; if (seq_done !== 1'b1 || seq_logic_clr !== 1'b1 || seq_tim_enable !== 1'b0)
                        begin errors++; $display("FAIL rnd_done it%0d got %0b%0b%0b want 110", it, seq_done, seq_logic_clr, seq_tim_enable); end
                end else begin
                    checks++; if (seq_prof_idx !== 2'(q[k+1]) || seq_done !== 1'b0)
                        begin errors++; $display("FAIL rnd_idx it%0d k%0d got %0d done %0b want %0d done 0", it, k, seq_prof_idx, seq_done, q[k+1]); end
                end
            end
            if (loop_en != 0) begin
                pulse(2);
                checks++; if (seq_logic_clr !== 1'b1 || seq_done !== 1'b0 || seq_tim_enable !== 1'b0)
                    begin errors++; $display("FAIL rnd_stop it%0d got clr %0b done %0b en %0b want 1 0 0", it, seq_logic_clr, seq_done, seq_tim_enable); end
            end
            tick();
            checks++; if (seq_logic_clr !== 1'b0 || seq_busy !== 1'b0 || seq_done !== 1'b0)
                begin errors++; $display("FAIL rnd_idle it%0d got clr %0b busy %0b done %0b want 0 0 0", it, seq_logic_clr, seq_busy, seq_done); end
            tick();
        end
    endtask

    task automatic test_fault();
        write_prof(0, 16'd100, 16'd10, 2);
        write_prof(1, 16'd200, 16'd20, 1);
        seq_last = 2'd1; seq_loop = 1'b0;
        tick();
        launch(16'd100);
        pulse(0);
        gen_reloaded = 1'b1; fault_detected = 1'b1;
        tick();
        gen_reloaded = 1'b0;
        checks++; if (seq_fault !== 1'b1 || seq_logic_clr !== 1'b1 || seq_tim_enable !== 1'b0 || seq_busy !== 1'b0)
            begin errors++; $display("FAIL flt_enter got f%0b c%0b e%0b b%0b want 1 1 0 0", seq_fault, seq_logic_clr, seq_tim_enable, seq_busy); end
        checks++; if (seq_prof_idx !== 2'd0) begin errors++; $display("FAIL flt_idx got %0d want 0", seq_prof_idx); end
        tick();
        checks++; if (seq_logic_clr !== 1'b0 || seq_fault !== 1'b1) begin errors++; $display("FAIL flt_hold got c%0b f%0b want 0 1", seq_logic_clr, seq_fault); end
        pulse(3);
        tick();
        checks++; if (seq_fault !== 1'b1) begin errors++; $display("FAIL flt_clr_blocked got %0b want 1", seq_fault); end
        fault_detected = 1'b0;
        pulse(3);
        checks++; if (seq_fault !== 1'b0 || seq_busy !== 1'b0) begin errors++; $display("FAIL flt_clr got f%0b b%0b want 0 0", seq_fault, seq_busy); end
        tick();
    endtask

    task automatic test_rep0_prewrite();
        write_prof(0, 16'd300, 16'd30, 0);
        write_prof(1, 16'd400, 16'd40, 1);
        seq_last = 2'd1; seq_loop = 1'b0;
        tick();
        launch(16'd300);
        gen_hw_update = 1'b1;
        prof_wr_en = 1'b1; prof_wr_idx = 2'd1; prof_wr_arr = 16'd555; prof_wr_cc1 = 16'd55; prof_wr_rep = REPW'(1);
        tick();
        gen_hw_update = 1'b0; prof_wr_en = 1'b0;
        m_arr[1] = 16'd555; m_cc1[1] = 16'd55;
        checks++; if (seq_arr !== 16'd400 || seq_cc1 !== 16'd40) begin errors++; $display("FAIL prewrite got %0d/%0d want 400/40", seq_arr, seq_cc1); end
        pulse(1);
        checks++; if (seq_prof_idx !== 2'd1) begin errors++; $display("FAIL rep0_idx got %0d want 1", seq_prof_idx); end
        pulse(0);
        checks++; if (seq_arr !== 16'd400) begin errors++; $display("FAIL last_hold got %0d want 400", seq_arr); end
        pulse(1);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL rep0_done got %0b want 1", seq_done); end
        idle_gap(2);
    endtask

    task automatic test_ignored_cmds();
        pulse(2);
        checks++; if (seq_logic_clr !== 1'b0 || seq_busy !== 1'b0) begin errors++; $display("FAIL idle_stop got c%0b b%0b want 0 0", seq_logic_clr, seq_busy); end
        pulse(1); pulse(0);
        checks++; if (seq_arr !== m_arr[0] || seq_tim_enable !== 1'b0) begin errors++; $display("FAIL idle_gen got %0d e%0b want %0d e0", seq_arr, seq_tim_enable, m_arr[0]); end
        launch(m_arr[0]);
        seq_start = 1'b1; tick(); seq_start = 1'b0;
        checks++; if (seq_tim_enable !== 1'b1 || seq_busy !== 1'b1) begin errors++; $display("FAIL run_start got e%0b b%0b want 1 1", seq_tim_enable, seq_busy); end
        pulse(2);
        checks++; if (seq_logic_clr !== 1'b1 || seq_done !== 1'b0) begin errors++; $display("FAIL run_stop got c%0b d%0b want 1 0", seq_logic_clr, seq_done); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        write_prof(0, 16'd900, 16'd90, 3);
        tick();
        launch(16'd900);
        pulse(1);
        pe_gen_rst = 1'b1;
        tick();
        pe_gen_rst = 1'b0;
        model_reset_table();
        checks++; if (seq_arr !== 16'h0032 || seq_cc1 !== 16'h0000 || seq_prof_idx !== 2'd0)
            begin errors++; $display("FAIL mid_rst_vals got %h/%h/%0d want 0032/0000/0", seq_arr, seq_cc1, seq_prof_idx); end
        checks++; if ({seq_tim_enable, seq_logic_clr, seq_busy, seq_done, seq_fault} !== 5'b0)
            begin errors++; $display("FAIL mid_rst_flags got %b want 00000", {seq_tim_enable, seq_logic_clr, seq_busy, seq_done, seq_fault}); end
        launch(16'h0032);
        pulse(2);
        tick();
    endtask

`ifdef ADVTIM_SEQ_WDOG_EN
    task automatic test_watchdog();
        int n;
        seq_wdog_lim = 24'd50;
        launch(m_arr[0]);
        n = 0;
        while (seq_wdog_to !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (n != 50 || seq_fault !== 1'b1) begin errors++; $display("FAIL wdog got cycles %0d fault %0b want 50 1", n, seq_fault); end
        seq_wdog_lim = 24'd0;
        pulse(3);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_random_profiles();
        test_fault();
        test_rep0_prewrite();
        test_ignored_cmds();
        test_reset_mid_run();
`ifdef ADVTIM_SEQ_WDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/advtim_seq_ctrl.md
ADVTIM_SEQ_CTRL -- requirements
Module: advtim_seq_ctrl

Interface
REQ-001 SHALL have parameter NPROF, default 4, number of profile slots (index width 2).
REQ-002 SHALL have parameter REPW, default 8, width of per-profile repeat count.
REQ-003 pe_gen_clk  in  1  single clock; all logic on rising edge.
REQ-004 pe_gen_rst  in  1  reset, synchronous, active-high.
REQ-005 seq_start / seq_stop / seq_fault_clr  in  1 each  single-cycle command pulses.
REQ-006 seq_loop  in  1  level: after last profile, wrap to profile 0 instead of finishing.
REQ-007 seq_last  in  2  index of last profile used.
REQ-008 prof_wr_en  in  1, prof_wr_idx  in  2, prof_wr_arr  in  16, prof_wr_cc1  in  16, prof_wr_rep  in  REPW: profile table write port.
REQ-009 gen_hw_update  in  1  generator pre-end pulse; gen_reloaded  in  1  generator period-end pulse; fault_detected  in  1  level.
REQ-010 seq_tim_enable  out  1  drives generator pe_gen_tim_enable; seq_logic_clr  out  1  drives pe_gen_logic_clr.
REQ-011 seq_arr  out  16, seq_cc1  out  16  drive generator r_arr / r_cc1.
REQ-012 seq_prof_idx  out  2 active profile; seq_busy  out  1; seq_done  out  1 pulse; seq_fault  out  1 level.

Function
REQ-013 FSM states SHALL be IDLE, LAUNCH, RUN, STOP, FAULT; all outputs registered.
REQ-014 Profile write SHALL update slot prof_wr_idx next cycle in any state; rep value 0 SHALL be treated as 1.
REQ-015 IDLE: seq_tim_enable=0, seq_busy=0, seq_arr/seq_cc1 track slot 0 every cycle.
REQ-016 IDLE + seq_start (no fault) -> LAUNCH: idx=0, rep_cnt=0, seq_busy=1.
REQ-017 LAUNCH SHALL last exactly 1 cycle, then RUN; seq_tim_enable rises on LAUNCH->RUN edge and stays 1 throughout RUN.
REQ-018 RUN: each gen_reloaded SHALL increment rep_cnt (REPW bits) unless it completes the profile.
REQ-019 gen_hw_update with rep_cnt==rep-1 SHALL load seq_arr/seq_cc1 from next slot (idx+1, or 0 if idx==seq_last and seq_loop=1) next cycle; if idx==seq_last and seq_loop=0, outputs hold.
REQ-020 gen_reloaded with rep_cnt==rep-1 SHALL set rep_cnt=0 and idx=next; if idx==seq_last and seq_loop=0, go STOP and pulse seq_done 1 cycle.
REQ-021 Table write to slot chosen in the same cycle as REQ-019 selection SHALL use the pre-write value.
REQ-022 seq_stop in LAUNCH/RUN -> STOP without seq_done; seq_stop in IDLE ignored; seq_start outside IDLE ignored.
REQ-023 STOP: seq_tim_enable=0, seq_logic_clr=1 for exactly 1 cycle, then IDLE.
REQ-024 fault_detected high in any state SHALL -> FAULT next cycle: seq_tim_enable=0, seq_logic_clr pulses 1 cycle, seq_fault=1, seq_busy=0.
REQ-025 FAULT exits to IDLE only on seq_fault_clr with fault_detected low; seq_fault clears then.
REQ-026 Priority same cycle: fault > seq_stop > gen_reloaded > gen_hw_update.
REQ-027 gen_hw_update/gen_reloaded outside RUN SHALL be ignored.

Reset
REQ-028 pe_gen_rst SHALL force IDLE, idx=0, rep_cnt=0, table slots arr=16'h0032, cc1=0, rep=1, all outputs 0 except seq_arr=16'h0032, mid-operation included.

Configuration
REQ-029 Macro ADVTIM_SEQ_WDOG_EN defined: adds input seq_wdog_lim[23:0] and output seq_wdog_to(1); in RUN a 24-bit counter clears on entry and each gen_reloaded; reaching seq_wdog_lim (nonzero) SHALL pulse seq_wdog_to and enter FAULT as REQ-024.
REQ-030 Macro undefined: ports and counter absent, no timeout behaviour.

Verification
REQ-031 slots {arr 100,rep 2},{arr 200,rep 1}, seq_last=1, loop=0, start -> seq_arr 100 then 200 one cycle after 2nd hw_update; done pulse after 3rd reloaded; logic_clr 1 cycle.
REQ-032 same, loop=1, 6 reloads -> idx 0,0,1,0,0,1 sequence; no seq_done; seq_stop -> STOP, logic_clr pulse, IDLE.
REQ-033 fault_detected during RUN same cycle as gen_reloaded -> FAULT, rep_cnt unchanged; seq_fault_clr with fault high ignored, with fault low -> IDLE.
REQ-034 rep=0 slot -> behaves as rep=1; write slot 1 during hw_update selecting slot 1 -> old value output.
REQ-035 pe_gen_rst asserted in RUN -> next cycle all REQ-028 values; seq_start after reset launches normally.
REQ-036 (ADVTIM_SEQ_WDOG_EN) lim=50, no gen_reloaded -> seq_wdog_to at 50th RUN cycle, FAULT next.
